// File: rtl/pipe_reg_skid_if.sv
// Handshake bundle for pipe_reg_skid: upstream push side, downstream pop side and occupancy.
// The slave modport is the stage itself; master is the environment driving it.
interface pipe_reg_skid_if #(
    parameter int unsigned DATAWIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic [1:0]           level;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  level
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output level
    );
endinterface

// File: rtl/pipe_reg_skid.sv
// Two-entry registered skid stage with valid/ready on both sides.
// Optional stall counter enabled by defining PIPE_REG_SKID_STALL_CNT_EN.
module pipe_reg_skid #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             flush,
    pipe_reg_skid_if.slave   bus
`ifdef PIPE_REG_SKID_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] main_q, main_d;
    logic [DATAWIDTH-1:0] skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 push, pop;

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (state_q != StEmpty) && bus.out_ready;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        main_d  = bus.in_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_d = bus.in_data;
                    end else if (push) begin
                        skid_d  = bus.in_data;
                        state_d = StFull;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Ready is a flop so it never depends combinationally on out_ready.
        in_ready_d = (state_d != StFull);
    end

    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = (state_q != StEmpty);
        bus.out_data  = main_q;
        bus.level     = state_q;
    end

`ifdef PIPE_REG_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if ((state_q != StEmpty) && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid; stall counter checks run when PIPE_REG_SKID_STALL_CNT_EN is set.
module tb_pipe_reg_skid;

    logic clk   = 1'b0;
    logic Rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_reg_skid_if #(.DATAWIDTH(32)) bus ();

`ifdef PIPE_REG_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipe_reg_skid #(.DATAWIDTH(32)) dut (
        .clk   (clk),
        .Rst_n (Rst_n),
        .flush (flush),
        .bus   (bus.slave)
`ifdef PIPE_REG_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                              input logic [1:0] lvl, input logic rdy);
        check_eq({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        if (v) check_eq({tag, ".out_data"}, bus.out_data, d);
        check_eq({tag, ".level"}, {30'd0, bus.level}, {30'd0, lvl});
        check_eq({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0);
        step();
        step();
        check_eq("rst.out_data", bus.out_data, 32'h0);
        expect_out("rst", 1'b0, 32'h0, 2'd0, 1'b0);
        Rst_n = 1'b1;
        step();
        expect_out("rst_rel", 1'b0, 32'h0, 2'd0, 1'b1);

        // Streaming at full rate
        drive(1'b1, 32'h11, 1'b1);
        step();
        expect_out("str0", 1'b1, 32'h11, 2'd1, 1'b1);
        drive(1'b1, 32'h22, 1'b1);
        step();
        expect_out("str1", 1'b1, 32'h22, 2'd1, 1'b1);
        drive(1'b1, 32'h33, 1'b1);
        step();
        expect_out("str2", 1'b1, 32'h33, 2'd1, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        step();
        expect_out("str_end", 1'b0, 32'h0, 2'd0, 1'b1);

        // Stall and skid
        drive(1'b1, 32'hA5, 1'b0);
        step();
        expect_out("skid0", 1'b1, 32'hA5, 2'd1, 1'b1);
        drive(1'b1, 32'h5A, 1'b0);
        step();
        expect_out("skid1", 1'b1, 32'hA5, 2'd2, 1'b0);
        drive(1'b1, 32'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("skid_hold", 1'b1, 32'hA5, 2'd2, 1'b0);
        end
        drive(1'b1, 32'hFF, 1'b1);
        step();
        expect_out("drain0", 1'b1, 32'h5A, 2'd1, 1'b1);
        step();
        expect_out("drain1", 1'b1, 32'hFF, 2'd1, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        step();
        expect_out("drain2", 1'b0, 32'h0, 2'd0, 1'b1);

        // Flush beats a pop in FULL
        drive(1'b1, 32'h10, 1'b0);
        step();
        drive(1'b1, 32'h20, 1'b0);
        step();
        expect_out("fl_full", 1'b1, 32'h10, 2'd2, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("flush", 1'b0, 32'h0, 2'd0, 1'b1);
        step();
        expect_out("flush_after", 1'b0, 32'h0, 2'd0, 1'b1);

        // ONE with push and pop together
        drive(1'b1, 32'h01, 1'b0);
        step();
        expect_out("one0", 1'b1, 32'h01, 2'd1, 1'b1);
        drive(1'b1, 32'h02, 1'b1);
        step();
        expect_out("one_pp", 1'b1, 32'h02, 2'd1, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        step();
        expect_out("one_end", 1'b0, 32'h0, 2'd0, 1'b1);

        // Asynchronous reset mid-cycle while FULL
        drive(1'b1, 32'h77, 1'b0);
        step();
        drive(1'b1, 32'h88, 1'b0);
        step();
        expect_out("ar_full", 1'b1, 32'h77, 2'd2, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        #2;
        Rst_n = 1'b0;
        #1;
        check_eq("ar.out_data", bus.out_data, 32'h0);
        expect_out("ar", 1'b0, 32'h0, 2'd0, 1'b0);
        #1;
        Rst_n = 1'b1;
        step();
        expect_out("ar_rel", 1'b0, 32'h0, 2'd0, 1'b1);

`ifdef PIPE_REG_SKID_STALL_CNT_EN
        drive(1'b1, 32'h42, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check_eq("sc.start", {16'd0, stall_cnt}, 32'd0);
        repeat (5) step();
        check_eq("sc.five", {16'd0, stall_cnt}, 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("sc.flush", {16'd0, stall_cnt}, 32'd0);
        drive(1'b1, 32'h43, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        check_eq("sc.sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Two-entry registered pipeline stage with valid/ready handshake on both sides. It is the consuming end of the producer-side data registers.
- It accepts a word from an upstream producer and holds it until the downstream consumer takes it.
- The skid entry absorbs one extra word when the consumer stalls, so upstream ready stays registered and the datapath can be cut for timing without throughput loss.
- It sits between datapath component stages wherever a register boundary needs backpressure.

Parameters:
- DATAWIDTH, 32, width of in_data/out_data in bits (ports are DATAWIDTH bits, index DATAWIDTH-1:0).

Ports:
- clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both entries.
- in_valid  input  1  upstream word present.
- in_ready  output  1  stage can accept a word; registered.
- in_data  input  DATAWIDTH  upstream word.
- out_valid  output  1  out_data holds a valid word; registered.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATAWIDTH  head word; registered.
- level  output  2  occupancy: 0, 1 or 2.

Behaviour:
- Transfer rules:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Both are evaluated at the rising edge of clk.
- Reset (Rst_n low, asynchronous): state EMPTY, out_valid=0, out_data=0, in_ready=0, level=0, skid storage=0. in_ready rises on the first clk edge after Rst_n deasserts.
- States and storage:
  - States: EMPTY (level 0), ONE (main entry valid, level 1), FULL (main and skid valid, level 2).
  - out_data always reflects the main entry.
  - in_ready=1 in EMPTY and ONE; in_ready=0 in FULL.
- Transitions, with flush taking priority over everything:
  - flush=1: next state EMPTY, out_valid=0, level=0, in_ready=1. A concurrent push or pop is discarded; no word is delivered or kept. out_data value is don't-care.
  - EMPTY, push: main<=in_data; next state ONE.
  - EMPTY, no push: stay EMPTY.
  - ONE, push and pop: main<=in_data; stay ONE.
  - ONE, push only: skid<=in_data; next state FULL; main unchanged.
  - ONE, pop only: next state EMPTY.
  - ONE, neither: hold.
  - FULL, pop: main<=skid; next state ONE. in_ready is 0, so no push is possible.
  - FULL, no pop: hold.
- Latency and throughput:
  - Latency is 1 cycle: a word pushed at edge N is on out_data with out_valid=1 after edge N.
  - Sustained throughput is 1 word/clk when out_ready stays high.
- Ordering: words leave in push order; no word is duplicated or dropped except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Ignored inputs: in_valid when in_ready=0 has no effect. in_data is don't-care when in_valid=0.
- No combinational path exists from out_ready to in_ready or from in_valid to out_valid.
- level equals the state encoding exactly on every cycle.
- Reset mid-operation: all held words are lost immediately; outputs take their reset values asynchronously.

Optional Feature:
- Macro: PIPE_REG_SKID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Increments by 1 on each clk edge where out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by Rst_n low or by flush=1; flush takes priority over increment.
- Not defined: the stall_cnt port and its counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset: drive Rst_n=0 mid-cycle with level=2 -> immediately out_valid=0, out_data=0, level=0, in_ready=0. Release Rst_n -> in_ready=1 after the next edge.
2. Streaming: out_ready=1, push 0x11, 0x22, 0x33 on consecutive edges -> out_data 0x11, 0x22, 0x33 on the following consecutive cycles with out_valid=1. level stays 1; in_ready stays 1.
3. Stall and skid: out_ready=0, push 0xA5, then 0x5A -> level=2, in_ready=0, out_data=0xA5. Hold in_valid with 0xFF for 3 cycles -> no change. Raise out_ready -> 0xA5, then 0x5A, then 0xFF delivered in order.
4. Flush priority: in FULL with pop and flush asserted together -> next cycle level=0, out_valid=0, in_ready=1, and nothing is delivered.
5. ONE-state simultaneous events: in ONE holding 0x01, push 0x02 and pop on the same edge -> out_data=0x02, level=1.
6. With PIPE_REG_SKID_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. Flush -> stall_cnt=0. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
